// File: rtl/bpsk_rx_frame_ctrl.sv
// Frame sequencer for the BPSK demapper: gates samples, hunts sync, packs payload bytes.
// Optional BPSK_POLARITY_RESOLVE_EN also accepts the inverted sync word and flips payload bits.
module bpsk_rx_frame_ctrl #(
  parameter int unsigned SYNC_LEN = 16,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = 16'hA5F0,
  parameter int unsigned PAYLOAD_BYTES = 8,
  parameter int unsigned HUNT_TIMEOUT = 1024
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               abort,
  input  logic               valid_s,
  input  logic signed [10:0] sr,
  input  logic signed [10:0] si,
  output logic               dm_valid,
  output logic signed [10:0] dm_ar,
  output logic signed [10:0] dm_ai,
  input  logic               dm_valid_x,
  input  logic               dm_x,
  output logic               busy,
  output logic               byte_valid,
  output logic [7:0]         byte_data,
  output logic               frame_done,
  output logic               sync_err
);

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    PAYLOAD
  } state_t;

  state_t state;

  logic [SYNC_LEN-1:0] sreg;
  logic [SYNC_LEN-1:0] sreg_nx;
  logic [15:0]         hcnt;
  logic [16:0]         hcnt_inc;
  logic [7:0]          acc;
  logic [7:0]          acc_nx;
  logic [7:0]          bcnt;
  logic [2:0]          bitcnt;
  logic                match;
  logic                match_i;
  logic                timeout;
  logic                pbit;

  assign sreg_nx  = {sreg[SYNC_LEN-2:0], dm_x};
  assign hcnt_inc = {1'b0, hcnt} + 17'd1;
  assign timeout  = (hcnt_inc == 17'(HUNT_TIMEOUT));
  assign match    = (sreg_nx == SYNC_WORD)
                 && (hcnt_inc >= 17'(SYNC_LEN));

`ifdef BPSK_POLARITY_RESOLVE_EN
  logic pol;

  assign match_i = (sreg_nx == ~SYNC_WORD)
                && (hcnt_inc >= 17'(SYNC_LEN));
  assign pbit    = dm_x ^ pol;

  // True match wins, so the flag only sets on a pure inverse hit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pol <= 1'b0;
    end else if (abort || state == IDLE) begin
      pol <= 1'b0;
    end else if (state == HUNT && dm_valid_x
                 && !match && match_i) begin
      pol <= 1'b1;
    end
  end
`else
  assign match_i = 1'b0;
  assign pbit    = dm_x;
`endif

  assign acc_nx = {acc[6:0], pbit};
  assign busy   = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      dm_valid   <= 1'b0;
      dm_ar      <= '0;
      dm_ai      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      sreg       <= '0;
      hcnt       <= '0;
      acc        <= '0;
      bcnt       <= '0;
      bitcnt     <= '0;
    end else begin
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      dm_valid   <= valid_s && (state != IDLE) && !abort;
      if (valid_s) begin
        dm_ar <= sr;
        dm_ai <= si;
      end
      if (abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state  <= HUNT;
              sreg   <= '0;
              hcnt   <= '0;
              acc    <= '0;
              bcnt   <= '0;
              bitcnt <= '0;
            end
          end
          HUNT: begin
            if (dm_valid_x) begin
              sreg <= sreg_nx;
              if (hcnt != 16'hFFFF) hcnt <= hcnt_inc[15:0];
              if (match || match_i) begin
                state <= PAYLOAD;
              end else if (timeout) begin
                state    <= IDLE;
                sync_err <= 1'b1;
              end
            end
          end
          PAYLOAD: begin
            // Stay one extra cycle so a start alongside frame_done is ignored.
            if (frame_done) begin
              state <= IDLE;
            end else if (dm_valid_x) begin
              acc    <= acc_nx;
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                byte_data  <= acc_nx;
                byte_valid <= 1'b1;
                bcnt       <= bcnt + 8'd1;
                if (bcnt == 8'(PAYLOAD_BYTES - 1)) frame_done <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
